// File: rtl/weight_map_gen.sv
// -----------------------------------------------------------------------------
// weight_map_gen
//
// Purpose:
//   Streams a weight per pixel for the ball-tracking colour accumulator. For
//   each valid (VtcHCnt, VtcVCnt) the Chebyshev ring distance to the tracked
//   centre is found, and the weight for that ring is read from a small
//   runtime-writable table. The centre is double-buffered: center_valid loads
//   a shadow copy, and frame_start moves it to the active copy, so the map
//   never changes in the middle of a frame.
//
// Optional build macro:
//   WEIGHT_SCORE_EN - adds mask_in / frame_end inputs and score /
//   score_valid outputs, plus the SCORE_W parameter. The weights of masked
//   pixels are summed per frame with saturation.
//
// Ports:
//   PCLK, RST          pixel clock, asynchronous active-high reset
//   frame_start        pulse on the first pixel of a frame (applies centre)
//   pix_valid          VtcHCnt / VtcVCnt valid this cycle
//   VtcHCnt, VtcVCnt   pixel coordinate
//   center_h/_v        new centre, captured when center_valid is high
//   tbl_we/addr/wdata  weight table write port (out-of-range addr ignored)
//   weight, ring_idx   per-pixel result, 3 PCLK after pix_valid
//   weight_valid       result strobe
//   mask_in, frame_end, score, score_valid   (WEIGHT_SCORE_EN only)
// -----------------------------------------------------------------------------
module weight_map_gen #(
    parameter int H_W       = 12,
    parameter int V_W       = 11,
    parameter int NUM_RINGS = 8,
    parameter int RING_H    = 20,
    parameter int RING_V    = 15,
    parameter int WEIGHT_W  = 4,
`ifdef WEIGHT_SCORE_EN
    parameter int SCORE_W   = 24,
`endif
    parameter logic [NUM_RINGS*WEIGHT_W-1:0] WEIGHT_INIT = 32'h122359DF,
    localparam int RI_W     = $clog2(NUM_RINGS)
) (
    input  logic                PCLK,
    input  logic                RST,
    input  logic                frame_start,
    input  logic                pix_valid,
    input  logic [H_W-1:0]      VtcHCnt,
    input  logic [V_W-1:0]      VtcVCnt,
    input  logic [H_W-1:0]      center_h,
    input  logic [V_W-1:0]      center_v,
    input  logic                center_valid,
    input  logic                tbl_we,
    input  logic [RI_W-1:0]     tbl_addr,
    input  logic [WEIGHT_W-1:0] tbl_wdata,
`ifdef WEIGHT_SCORE_EN
    input  logic                mask_in,
    input  logic                frame_end,
    output logic [SCORE_W-1:0]  score,
    output logic                score_valid,
`endif
    output logic [WEIGHT_W-1:0] weight,
    output logic [RI_W-1:0]     ring_idx,
    output logic                weight_valid
);

    function automatic logic [H_W-1:0] abs_h(input logic signed [H_W:0] d);
        logic signed [H_W:0] m;
        m = (d < 0) ? -d : d;
        return m[H_W-1:0];
    endfunction

    function automatic logic [V_W-1:0] abs_v(input logic signed [V_W:0] d);
        logic signed [V_W:0] m;
        m = (d < 0) ? -d : d;
        return m[V_W-1:0];
    endfunction

    // Each k whose threshold is reached on either axis adds one ring; the
    // loop stops at NUM_RINGS-1, which gives the saturation for free.
    function automatic logic [RI_W-1:0] ring_of(input logic [H_W-1:0] dh,
                                                input logic [V_W-1:0] dv);
        logic [RI_W-1:0] n;
        n = '0;
        for (int k = 1; k < NUM_RINGS; k++) begin
            if ((32'(dh) >= 32'(k * RING_H)) || (32'(dv) >= 32'(k * RING_V)))
                n = n + RI_W'(1);
        end
        return n;
    endfunction

    // Centre double buffer
    logic [H_W-1:0] r_shadow_h, r_active_h, w_cen_h;
    logic [V_W-1:0] r_shadow_v, r_active_v, w_cen_v;

    // A centre arriving together with frame_start bypasses the shadow so the
    // first pixel of the frame already sees it.
    always_comb begin
        w_cen_h = r_active_h;
        w_cen_v = r_active_v;
        if (frame_start) begin
            if (center_valid) begin
                w_cen_h = center_h;
                w_cen_v = center_v;
            end else begin
                w_cen_h = r_shadow_h;
                w_cen_v = r_shadow_v;
            end
        end
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_shadow_h <= '0;
            r_shadow_v <= '0;
            r_active_h <= '0;
            r_active_v <= '0;
        end else begin
            if (center_valid) begin
                r_shadow_h <= center_h;
                r_shadow_v <= center_v;
            end
            if (frame_start) begin
                r_active_h <= w_cen_h;
                r_active_v <= w_cen_v;
            end
        end
    end

    // Weight table
    logic [WEIGHT_W-1:0] r_tbl [NUM_RINGS];
    logic                w_addr_ok;

    if ((2 ** RI_W) == NUM_RINGS) begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign w_addr_ok = ({1'b0, tbl_addr} < (RI_W + 1)'(NUM_RINGS));
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_RINGS; i++)
                r_tbl[i] <= WEIGHT_INIT[i*WEIGHT_W +: WEIGHT_W];
        end else if (tbl_we && w_addr_ok) begin
            r_tbl[tbl_addr] <= tbl_wdata;
        end
    end

    // Pipeline valids
    logic r_vld_p1, r_vld_p2, r_vld_p3;

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_vld_p1 <= pix_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // Stage 1: absolute distance per axis
    logic signed [H_W:0] w_dx;
    logic signed [V_W:0] w_dy;
    logic [H_W-1:0]      r_dh_p1;
    logic [V_W-1:0]      r_dv_p1;

    assign w_dx = $signed({1'b0, VtcHCnt}) - $signed({1'b0, w_cen_h});
    assign w_dy = $signed({1'b0, VtcVCnt}) - $signed({1'b0, w_cen_v});

    always_ff @(posedge PCLK) begin
        if (pix_valid) begin
            r_dh_p1 <= abs_h(w_dx);
            r_dv_p1 <= abs_v(w_dy);
        end
    end

    // Stage 2: ring index
    logic [RI_W-1:0] r_ring_p2;

    always_ff @(posedge PCLK) begin
        if (r_vld_p1)
            r_ring_p2 <= ring_of(r_dh_p1, r_dv_p1);
    end

    // Stage 3: table lookup (reads the pre-write value on a same-cycle write)
    logic [WEIGHT_W-1:0] r_weight_p3;
    logic [RI_W-1:0]     r_ring_p3;

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_weight_p3 <= '0;
            r_ring_p3   <= '0;
        end else if (r_vld_p2) begin
            r_weight_p3 <= r_tbl[r_ring_p2];
            r_ring_p3   <= r_ring_p2;
        end
    end

    assign weight       = r_weight_p3;
    assign ring_idx     = r_ring_p3;
    assign weight_valid = r_vld_p3;

`ifdef WEIGHT_SCORE_EN
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [WEIGHT_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    logic                r_mask_p1, r_mask_p2, r_fend_p1, r_fend_p2;
    logic [SCORE_W-1:0]  r_acc_p3, r_score_p3, w_sum;
    logic                r_score_vld_p3;
    logic [WEIGHT_W-1:0] w_contrib;

    assign w_contrib = (r_vld_p2 && r_mask_p2) ? r_tbl[r_ring_p2] : '0;
    assign w_sum     = sat_add(r_acc_p3, w_contrib);

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_mask_p1      <= 1'b0;
            r_mask_p2      <= 1'b0;
            r_fend_p1      <= 1'b0;
            r_fend_p2      <= 1'b0;
            r_acc_p3       <= '0;
            r_score_p3     <= '0;
            r_score_vld_p3 <= 1'b0;
        end else begin
            r_mask_p1      <= mask_in;
            r_mask_p2      <= r_mask_p1;
            r_fend_p1      <= frame_end;
            r_fend_p2      <= r_fend_p1;
            r_score_vld_p3 <= r_fend_p2;
            if (r_fend_p2) begin
                r_score_p3 <= w_sum;
                r_acc_p3   <= '0;
            end else begin
                r_acc_p3   <= w_sum;
            end
        end
    end

    assign score       = r_score_p3;
    assign score_valid = r_score_vld_p3;
`endif

endmodule

// File: tb/tb_weight_map_gen.sv
module tb_weight_map_gen;

    localparam int H_W       = 12;
    localparam int V_W       = 11;
    localparam int NUM_RINGS = 8;
    localparam int RING_H    = 20;
    localparam int RING_V    = 15;
    localparam int WEIGHT_W  = 4;
    localparam int RI_W      = $clog2(NUM_RINGS);
    localparam int SCORE_W   = 24;
    localparam logic [31:0] WINIT = 32'h122359DF;
    localparam longint SMAX  = (64'd1 << SCORE_W) - 1;

    logic                PCLK = 1'b0;
    logic                RST = 1'b1;
    logic                frame_start = 1'b0;
    logic                pix_valid = 1'b0;
    logic [H_W-1:0]      VtcHCnt = '0;
    logic [V_W-1:0]      VtcVCnt = '0;
    logic [H_W-1:0]      center_h = '0;
    logic [V_W-1:0]      center_v = '0;
    logic                center_valid = 1'b0;
    logic                tbl_we = 1'b0;
    logic [RI_W-1:0]     tbl_addr = '0;
    logic [WEIGHT_W-1:0] tbl_wdata = '0;
    logic                mask_in = 1'b0;
    logic                frame_end = 1'b0;
    logic [WEIGHT_W-1:0] weight;
    logic [RI_W-1:0]     ring_idx;
    logic                weight_valid;
`ifdef WEIGHT_SCORE_EN
    logic [SCORE_W-1:0]  score;
    logic                score_valid;
`endif

    always #5 PCLK = ~PCLK;

    weight_map_gen #(
        .H_W(H_W), .V_W(V_W), .NUM_RINGS(NUM_RINGS), .RING_H(RING_H),
        .RING_V(RING_V), .WEIGHT_W(WEIGHT_W),
`ifdef WEIGHT_SCORE_EN
        .SCORE_W(SCORE_W),
`endif
        .WEIGHT_INIT(WINIT)
    ) dut (
        .PCLK(PCLK), .RST(RST), .frame_start(frame_start), .pix_valid(pix_valid),
        .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .center_h(center_h),
        .center_v(center_v), .center_valid(center_valid), .tbl_we(tbl_we),
        .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
`ifdef WEIGHT_SCORE_EN
        .mask_in(mask_in), .frame_end(frame_end), .score(score),
        .score_valid(score_valid),
`endif
        .weight(weight), .ring_idx(ring_idx), .weight_valid(weight_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: ring = max(dh div RING_H, dv div RING_V), clamped.
    typedef struct { bit v; int r; bit m; bit f; } ent_t;
    ent_t   q[$];
    int     tbl[NUM_RINGS];
    int     sh_h, sh_v, ac_h, ac_v;
    int     m_w, m_r;
    bit     m_wv, m_sv;
    longint m_acc, m_score;

    function automatic int ring_ref(int x, int y, int cx, int cy);
        int dh, dv, r;
        dh = (x > cx) ? x - cx : cx - x;
        dv = (y > cy) ? y - cy : cy - y;
        r  = dh / RING_H;
        if (dv / RING_V > r) r = dv / RING_V;
        if (r > NUM_RINGS - 1) r = NUM_RINGS - 1;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back('{v: 1'b0, r: 0, m: 1'b0, f: 1'b0});
        q.push_back('{v: 1'b0, r: 0, m: 1'b0, f: 1'b0});
        for (int i = 0; i < NUM_RINGS; i++) tbl[i] = int'(WINIT[i*4 +: 4]);
        sh_h = 0; sh_v = 0; ac_h = 0; ac_v = 0;
        m_w = 0; m_r = 0; m_wv = 1'b0; m_sv = 1'b0;
        m_acc = 0; m_score = 0;
    endtask

    task automatic model_edge();
        ent_t   e;
        int     eh, ev, c;
        longint s;
        if (RST) begin
            model_reset();
            return;
        end
        e = q.pop_front();
        m_wv = e.v;
        if (e.v) begin
            m_w = tbl[e.r];
            m_r = e.r;
        end
        c = (e.v && e.m) ? tbl[e.r] : 0;
        s = m_acc + c;
        if (s > SMAX) s = SMAX;
        m_sv = e.f;
        if (e.f) begin
            m_score = s;
            m_acc   = 0;
        end else begin
            m_acc = s;
        end
        if (tbl_we && int'(tbl_addr) < NUM_RINGS) tbl[tbl_addr] = int'(tbl_wdata);
        eh = ac_h; ev = ac_v;
        if (frame_start) begin
            eh = center_valid ? int'(center_h) : sh_h;
            ev = center_valid ? int'(center_v) : sh_v;
        end
        q.push_back('{v: pix_valid, r: ring_ref(int'(VtcHCnt), int'(VtcVCnt), eh, ev),
                      m: mask_in, f: frame_end});
        if (center_valid) begin
            sh_h = int'(center_h);
            sh_v = int'(center_v);
        end
        if (frame_start) begin
            ac_h = eh;
            ac_v = ev;
        end
    endtask

    // One clock: advance the model, compare 1 time unit after the edge, and
    // drop the single-cycle pulses.
    task automatic cyc();
        @(posedge PCLK);
        model_edge();
        #1;
        chk("weight_valid", 32'(weight_valid), 32'(m_wv));
        chk("weight", 32'(weight), m_w);
        chk("ring_idx", 32'(ring_idx), m_r);
`ifdef WEIGHT_SCORE_EN
        chk("score_valid", 32'(score_valid), 32'(m_sv));
        chk("score", 32'(score), 32'(m_score));
`endif
        frame_start = 1'b0; center_valid = 1'b0; tbl_we = 1'b0;
        pix_valid = 1'b0; mask_in = 1'b0; frame_end = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input bit m = 1'b0, input bit f = 1'b0);
        pix_valid = 1'b1;
        VtcHCnt   = H_W'(x);
        VtcVCnt   = V_W'(y);
        mask_in   = m;
        frame_end = f;
    endtask

    task automatic set_centre(input int x, input int y);
        center_valid = 1'b1;
        center_h     = H_W'(x);
        center_v     = V_W'(y);
    endtask

    task automatic one(input int x, input int y, input int ew, input int er, input string tag);
        pix(x, y);
        repeat (3) cyc();
        chk({tag, "_vld"}, 32'(weight_valid), 32'd1);
        chk({tag, "_w"}, 32'(weight), ew);
        chk({tag, "_ring"}, 32'(ring_idx), er);
    endtask

    initial begin
        model_reset();
        repeat (2) cyc();
        chk("rst_vld", 32'(weight_valid), 32'd0);
        chk("rst_w", 32'(weight), 32'd0);
        chk("rst_ring", 32'(ring_idx), 32'd0);
        RST = 1'b0;

        // Centre applied together with frame_start
        set_centre(160, 120);
        frame_start = 1'b1;
        one(160, 120, 'hF, 0, "centre");
        one(179, 120, 'hF, 0, "dh19");
        one(180, 120, 'hD, 1, "dh20");
        one(160, 135, 'hD, 1, "dv15");
        one(0, 0, 'h1, 7, "origin");
        one(639, 479, 'h1, 7, "corner");

        // Mid-frame centre update waits for frame_start
        set_centre(300, 200);
        cyc();
        one(300, 200, 'h1, 7, "shadow_only");
        frame_start = 1'b1;
        one(300, 200, 'hF, 0, "applied");

        // Write entry 0 in the cycle that stage 3 reads it
        pix(300, 200);
        cyc();
        cyc();
        tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = 4'h7;
        cyc();
        chk("wr_old_w", 32'(weight), 32'hF);
        one(300, 200, 'h7, 0, "wr_new");

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            pix(300 + i, 200);
            cyc();
        end
        pix(303, 200);
        RST = 1'b1;
        #1;
        chk("rst_mid_vld", 32'(weight_valid), 32'd0);
        chk("rst_mid_w", 32'(weight), 32'd0);
        cyc();
        RST = 1'b0;
        one(0, 0, 'hF, 0, "rst_tbl");

`ifdef WEIGHT_SCORE_EN
        set_centre(160, 120);
        frame_start = 1'b1;
        pix(160, 120, 1'b1);       cyc();
        pix(170, 125, 1'b1);       cyc();
        pix(180, 120, 1'b1);       cyc();
        pix(0, 0, 1'b1, 1'b1);     cyc();
        cyc();
        cyc();
        chk("score_sum", 32'(score), 32'd44);
        chk("score_pulse", 32'(score_valid), 32'd1);
        cyc();
        chk("score_pulse_end", 32'(score_valid), 32'd0);
        pix(160, 120, 1'b1, 1'b1);
        repeat (3) cyc();
        chk("score_next", 32'(score), 32'd15);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pix_valid    = ($urandom_range(0, 3) != 0);
            VtcHCnt      = H_W'($urandom_range(0, 639));
            VtcVCnt      = V_W'($urandom_range(0, 479));
            frame_start  = ($urandom_range(0, 29) == 0);
            center_valid = ($urandom_range(0, 19) == 0);
            center_h     = H_W'($urandom_range(0, 639));
            center_v     = V_W'($urandom_range(0, 479));
            tbl_we       = ($urandom_range(0, 9) == 0);
            tbl_addr     = RI_W'($urandom_range(0, NUM_RINGS - 1));
            tbl_wdata    = WEIGHT_W'($urandom_range(0, 15));
            mask_in      = ($urandom_range(0, 1) != 0);
            frame_end    = ($urandom_range(0, 40) == 0);
            RST          = ($urandom_range(0, 299) == 0);
            cyc();
        end
        RST = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
